vga_timing_gen: RTL

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_timing_gen_if.sv | 17 +
 rtl/vga_axis_counter.sv | 56 +++++
 rtl/vga_timing_gen.sv | 81 ++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing types and 640x480@60 default constants.
package vga_pkg;

  typedef enum logic [1:0] {ACT, FP, SYN, BP} phase_e;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Phase that owns the final count of an axis (empty trailing phases skipped).
  function automatic phase_e last_phase(int act_len, int fp_len, int syn_len, int bp_len);
    if (bp_len > 0)       return BP;
    else if (syn_len > 0) return SYN;
    else if (fp_len > 0)  return FP;
    else                  return ACT;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Timing outputs of the generator as seen by a pixel pipeline.
interface vga_timing_gen_if;
  logic [11:0]          pixel_cnt;
  logic [11:0]          line_cnt;
  logic                 h_sync;
  logic                 v_sync;
  logic                 video_on;
  logic                 line_start;
  logic                 frame_start;
  vga_pkg::phase_e      h_phase;
  vga_pkg::phase_e      v_phase;

  modport master (output pixel_cnt, line_cnt, h_sync, v_sync, video_on,
                  line_start, frame_start, h_phase, v_phase);
  modport slave  (input  pixel_cnt, line_cnt, h_sync, v_sync, video_on,
                  line_start, frame_start, h_phase, v_phase);
endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap-by-compare counter plus ACT/FP/SYN/BP phase FSM.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACT_LEN = 640,
  parameter int FP_LEN  = 16,
  parameter int SYN_LEN = 96,
  parameter int BP_LEN  = 48
) (
  input  logic        rfr_clk,
  input  logic        reset,
  input  logic        adv,
  output logic [11:0] cnt,
  output phase_e      phase,
  output phase_e      phase_nxt,
  output logic        wrap
);

  localparam int          TOTAL  = ACT_LEN + FP_LEN + SYN_LEN + BP_LEN;
  localparam logic [11:0] LAST   = 12'(TOTAL - 1);
  localparam logic [11:0] B_FP   = 12'(ACT_LEN);
  localparam logic [11:0] B_SYN  = 12'(ACT_LEN + FP_LEN);
  localparam logic [11:0] B_BP   = 12'(ACT_LEN + FP_LEN + SYN_LEN);
  localparam phase_e      RST_PH = last_phase(ACT_LEN, FP_LEN, SYN_LEN, BP_LEN);

  logic [11:0] cnt_nxt;

  // Terminal count; the caller qualifies it with its own advance.
  assign wrap = (cnt == LAST);

  // Next count and phase. Boundaries that coincide (zero-length phase) are
  // resolved latest-first so an empty phase is never entered.
  always_comb begin
    cnt_nxt   = cnt;
    phase_nxt = phase;
    if (adv) begin
      cnt_nxt = wrap ? 12'd0 : cnt + 12'd1;
      if (cnt_nxt == B_BP && BP_LEN > 0)       phase_nxt = BP;
      else if (cnt_nxt == B_SYN && SYN_LEN > 0) phase_nxt = SYN;
      else if (cnt_nxt == B_FP && FP_LEN > 0)   phase_nxt = FP;
      else if (cnt_nxt == 12'd0 && ACT_LEN > 0) phase_nxt = ACT;
    end
  end

  // State register; reset parks on the last position so the first advance lands on 0.
  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      cnt   <= LAST;
      phase <= RST_PH;
    end else begin
      cnt   <= cnt_nxt;
      phase <= phase_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal and vertical axis counters with registered,
// position-aligned sync, blanking and start-pulse outputs.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = VGA_H_ACTIVE,
  parameter int   H_FP     = VGA_H_FP,
  parameter int   H_SYNC   = VGA_H_SYNC,
  parameter int   H_BP     = VGA_H_BP,
  parameter int   V_ACTIVE = VGA_V_ACTIVE,
  parameter int   V_FP     = VGA_V_FP,
  parameter int   V_SYNC   = VGA_V_SYNC,
  parameter int   V_BP     = VGA_V_BP,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic             rfr_clk,
  input  logic             reset,
  input  logic             en,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096 || H_TOTAL < 1) begin : g_bad_h_total
    $error("vga_timing_gen: H_TOTAL must be 1..4096");
  end
  if (V_TOTAL > 4096 || V_TOTAL < 1) begin : g_bad_v_total
    $error("vga_timing_gen: V_TOTAL must be 1..4096");
  end

  logic [11:0] h_cnt, v_cnt;
  phase_e      h_ph, h_ph_nxt, v_ph, v_ph_nxt;
  logic        h_wrap, v_wrap, v_adv;
  logic        hs_q, vs_q, von_q, ls_q, fs_q;

  // Lines advance on the same edge the pixel counter wraps.
  assign v_adv = h_wrap & en;

  vga_axis_counter #(
    .ACT_LEN(H_ACTIVE), .FP_LEN(H_FP), .SYN_LEN(H_SYNC), .BP_LEN(H_BP)
  ) u_h (
    .rfr_clk(rfr_clk), .reset(reset), .adv(en),
    .cnt(h_cnt), .phase(h_ph), .phase_nxt(h_ph_nxt), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACT_LEN(V_ACTIVE), .FP_LEN(V_FP), .SYN_LEN(V_SYNC), .BP_LEN(V_BP)
  ) u_v (
    .rfr_clk(rfr_clk), .reset(reset), .adv(v_adv),
    .cnt(v_cnt), .phase(v_ph), .phase_nxt(v_ph_nxt), .wrap(v_wrap)
  );

  // Decodes are registered from next-state so they line up with the counters.
  always_ff @(posedge rfr_clk) begin
    if (reset) begin
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      von_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      hs_q  <= (h_ph_nxt == SYN) ? SYNC_POL : ~SYNC_POL;
      vs_q  <= (v_ph_nxt == SYN) ? SYNC_POL : ~SYNC_POL;
      von_q <= (h_ph_nxt == ACT) && (v_ph_nxt == ACT);
      ls_q  <= en & h_wrap;
      fs_q  <= en & h_wrap & v_wrap;
    end
  end

  assign vid.pixel_cnt   = h_cnt;
  assign vid.line_cnt    = v_cnt;
  assign vid.h_phase     = h_ph;
  assign vid.v_phase     = v_ph;
  assign vid.h_sync      = hs_q;
  assign vid.v_sync      = vs_q;
  assign vid.video_on    = von_q;
  assign vid.line_start  = ls_q;
  assign vid.frame_start = fs_q;

endmodule
